// File: rtl/serial_bypass_subtractor_pkg.sv
`default_nettype none
// ---- serial_bypass_subtractor_pkg : FSM encoding and default geometry -- rev 1.0 ----
package serial_bypass_subtractor_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_GROUP   = 4;
  localparam int DEF_NGROUPS = DEF_WIDTH / DEF_GROUP;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_bypass_subtractor_sub_group_bypass.sv
`default_nettype none
// ---- sub_group_bypass : GROUP-bit ripple a + ~b + cin with all-propagate flag -- rev 1.0 ----
module sub_group_bypass
  import serial_bypass_subtractor_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] diff,
  output logic             cout,
  output logic             all_prop
);

  logic [GROUP:0]   c;
  logic [GROUP-1:0] p;

  assign c[0] = cin;
  assign p    = a ^ ~b;

  for (genvar i = 0; i < GROUP; i++) begin : g_bit
    assign diff[i]  = p[i] ^ c[i];
    assign c[i+1]   = (a[i] & ~b[i]) | (p[i] & c[i]);
  end

  assign cout     = c[GROUP];
  assign all_prop = &p;

endmodule
`default_nettype wire

// File: rtl/serial_bypass_subtractor.sv
`default_nettype none
// ---- serial_bypass_subtractor : GROUP bits per cycle a - b - bin, carry-bypass -- rev 1.0 ----
// ---- Optional signed overflow flag enabled by macro SUB_OVERFLOW_EN.
module serial_bypass_subtractor
  import serial_bypass_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NGROUPS = WIDTH / GROUP;
  localparam int KW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_nxt;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic [GROUP-1:0] grp_a, grp_b, grp_diff;
  logic             grp_ripple, grp_all_prop, grp_cout;
  logic             accept, last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_ready && in_valid;
  assign last      = (k_q == KW'(NGROUPS - 1));

  assign grp_a = a_q[int'(k_q) * GROUP +: GROUP];
  assign grp_b = b_q[int'(k_q) * GROUP +: GROUP];

  sub_group_bypass #(.GROUP(GROUP)) u_group (
    .a        (grp_a),
    .b        (grp_b),
    .cin      (carry_q),
    .diff     (grp_diff),
    .cout     (grp_ripple),
    .all_prop (grp_all_prop)
  );

  // Fully propagating group forwards its carry-in unchanged.
  assign grp_cout = grp_all_prop ? carry_q : grp_ripple;

  always_comb begin
    work_nxt = work_q;
    work_nxt[int'(k_q) * GROUP +: GROUP] = grp_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_CALC;
      S_CALC:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= ~bin;
      k_q     <= '0;
    end else if (state == S_CALC) begin
      work_q  <= work_nxt;
      carry_q <= grp_cout;
      if (last) begin
        k_q  <= '0;
        diff <= work_nxt;
        bout <= ~grp_cout;
      end else begin
        k_q  <= k_q + 1'b1;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  // At the last group the operand and result MSBs sit at the top of the group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (state == S_CALC && last)
      overflow <= (grp_a[GROUP-1] != grp_b[GROUP-1]) && (grp_diff[GROUP-1] != grp_a[GROUP-1]);
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_bypass_subtractor.sv
`default_nettype none
// ---- tb_serial_bypass_subtractor : randomized bench with arithmetic reference model -- rev 1.0 ----
module tb_serial_bypass_subtractor;

  localparam int W  = 32;
  localparam int NG = 8;
`ifdef SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_bypass_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {overflow, bout, diff} straight from the arithmetic definition
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0]   t;
    logic         ov;
    t  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    ov = OVF_EN && (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  // Protocol model: 0 idle, 1 busy, 2 result pending
  int           m_state = 0;
  int           m_cnt   = 0;
  bit           m_fresh = 1'b1;
  logic [W+1:0] m_exp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_fresh <= 1'b1;
    end else begin
      case (m_state)
        0: if (in_valid) begin
             m_exp   <= model(a, b, bin);
             m_cnt   <= 0;
             m_state <= 1;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt == NG - 1) begin
               m_state <= 2;
               m_fresh <= 1'b0;
             end
           end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(m_state == 0));
    check("out_valid", 64'(out_valid), 64'(m_state == 2));
    if (m_state == 2) begin
      check("diff", 64'(diff), 64'(m_exp[W-1:0]));
      check("bout", 64'(bout), 64'(m_exp[W]));
      check("overflow", 64'(overflow), 64'(m_exp[W+1]));
    end else if (m_fresh) begin
      check("diff_rst", 64'(diff), 64'd0);
      check("bout_rst", 64'(bout), 64'd0);
      check("ovf_rst", 64'(overflow), 64'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tbin,
                        input int hold, input bit lit,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    logic [W-1:0] d0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_wait", 64'(in_ready), 64'd1);
    a = ta; b = tb_b; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(NG));
    if (lit) begin
      check("lit_diff", 64'(diff), 64'(ed));
      check("lit_bout", 64'(bout), 64'(eb));
      check("lit_ovf", 64'(overflow), 64'(eo));
    end
    d0 = diff;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_diff", 64'(diff), 64'(d0));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    check("model_5_3", 64'(model(32'd5, 32'd3, 1'b0)), 64'h2);
    check("model_0_1", 64'(model(32'd0, 32'd1, 1'b0)), {30'd0, 1'b0, 1'b1, 32'hFFFFFFFF});
    check("model_min_1", 64'(model(32'h80000000, 32'd1, 1'b0)), {30'd0, OVF_EN, 1'b0, 32'h7FFFFFFF});

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd5, 32'd3, 1'b0, 0, 1'b1, 32'h00000002, 1'b0, 1'b0);
    run_op(32'd0, 32'd1, 1'b0, 2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b0, 0, 1'b1, 32'h7FFFFFFF, 1'b0, OVF_EN);
    run_op(32'h12345678, 32'h12345678, 1'b1, 0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 1'b0, '0, 1'b0, 1'b0);

    // Reset mid-calculation, after group 3 is pending
    a = 32'hDEADBEEF; b = 32'h01234567; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_diff", 64'(diff), 64'd0);
    check("midrst_bout", 64'(bout), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; check("no_stale_result", 64'(out_valid), 64'd0); end
    run_op(32'h00000010, 32'h00000001, 1'b1, 1, 1'b1, 32'h0000000E, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = ra;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 4)), 1'b0, '0, 1'b0, 1'b0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_bypass_subtractor.md
SERIAL_BYPASS_SUBTRACTOR -- requirements
Module: serial_bypass_subtractor

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be an integer multiple of GROUP.
REQ-002 Parameter GROUP, default 4: bits processed per CALC cycle; NGROUPS = WIDTH/GROUP (default 8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set a/b/bin is presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  minuend, unsigned or two's complement.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  diff/bout/overflow are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-013 bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
REQ-014 overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE after reset.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: in_valid=1 at a rising edge -> latch a, b, bin; group index k=0; go to CALC.
REQ-018 CALC: each edge processes group k as a + ~b + c with c = ~borrow (initially ~bin), writes GROUP diff bits, increments k.
REQ-019 Group carry-out SHALL come from the bypass mux: if all GROUP bits of a^~b are 1, pass group carry-in; else ripple carry.
REQ-020 On the edge processing k = NGROUPS-1: register diff, bout = ~final carry, overflow; go to DONE.
REQ-021 Latency: out_valid rises exactly NGROUPS rising edges after the accepting edge (8 by default).
REQ-022 DONE: diff/bout/overflow held stable until out_valid && out_ready at an edge; then go to IDLE.
REQ-023 No accept in DONE: in_valid ignored in CALC and DONE; next acceptance no earlier than the edge after the DONE->IDLE edge.
REQ-024 Input changes after the accepting edge SHALL NOT affect the in-flight result.

Reset
REQ-025 rst_n low, at any time including mid-CALC: state IDLE, k=0, diff=0, bout=0, overflow=0, out_valid=0, in_ready=1.
REQ-026 Operation in progress is discarded; no result emitted for it after reset release.

Configuration
REQ-027 Macro SUB_OVERFLOW_EN defined: overflow computed per REQ-014 and registered with diff.
REQ-028 Macro SUB_OVERFLOW_EN undefined: overflow port present, constant 0, no overflow logic.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding and the default WIDTH/GROUP/NGROUPS constants.
REQ-030 One sub-module sub_group_bypass: GROUP-bit ripple a + ~b + cin with diff bits, ripple carry and all-propagate flag; one instance, reused each CALC cycle.

Verification
REQ-031 a=5, b=3, bin=0 -> diff=0x00000002, bout=0, overflow=0; out_valid exactly 8 edges after accept.
REQ-032 a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, overflow=0.
REQ-033 a=0x80000000, b=1, bin=0 -> diff=0x7FFFFFFF, bout=0, overflow=1 with SUB_OVERFLOW_EN, 0 without.
REQ-034 a=b=0x12345678, bin=1 -> full bypass in every group; diff=0xFFFFFFFF, bout=1, overflow=0.
REQ-035 out_ready low 5 cycles in DONE while in_valid toggles and a/b change -> outputs stable, in_ready=0, no new accept.
REQ-036 rst_n pulsed low during CALC at k=3 -> all outputs 0, in_ready=1 immediately; new operands after release give a correct result.
